// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter and its access checker.
// Holds func3 encodings, arbiter state codes and the access-size helper.
package dmem_arbiter_pkg;

    localparam logic [2:0] F3_BYTE  = 3'd0;
    localparam logic [2:0] F3_HALF  = 3'd1;
    localparam logic [2:0] F3_WORD  = 3'd2;
    localparam logic [2:0] F3_UBYTE = 3'd4;
    localparam logic [2:0] F3_UHALF = 3'd5;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE   = 2'd0;
    localparam arb_state_t ACCESS = 2'd1;
    localparam arb_state_t RESP   = 2'd2;

    // Bytes touched by an access; 0 marks an encoding with no legal size.
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        logic [2:0] sz;
        case (f3)
            F3_BYTE, F3_UBYTE: sz = 3'd1;
            F3_HALF, F3_UHALF: sz = 3'd2;
            F3_WORD:           sz = 3'd4;
            default:           sz = 3'd0;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/dmem_access_check.sv
// Combinational legality check for one data-memory access.
// Flags bad func3, unsigned stores, misalignment and out-of-range bytes.
module dmem_access_check #(
    parameter int MEM_BYTES = 512
) (
    input  logic [2:0]  func3,
    input  logic        we,
    input  logic [31:0] addr,
    output logic        err
);

    import dmem_arbiter_pkg::*;

    logic [2:0]  size;
    logic [32:0] last;
    logic        bad_f3;
    logic        bad_st;
    logic        bad_al;
    logic        bad_rng;

    always_comb begin
        size   = f3_size(func3);
        bad_f3 = (size == 3'd0);
        bad_st = we && ((func3 == F3_UBYTE) || (func3 == F3_UHALF));
        bad_al = 1'b0;
        unique case (1'b1)
            (size == 3'd2): bad_al = addr[0];
            (size == 3'd4): bad_al = |addr[1:0];
            default:        bad_al = 1'b0;
        endcase
        // 33-bit sum so addresses near 2^32 cannot wrap into range.
        last    = {1'b0, addr} + {30'd0, size} - 33'd1;
        bad_rng = (last >= 33'(MEM_BYTES));
        err     = bad_f3 | bad_st | bad_al | bad_rng;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between NREQ masters.
// One access in flight: grant, memory cycle, then a one-cycle response.
module dmem_arbiter #(
    parameter int NREQ      = 2,
    parameter int MEM_BYTES = 512
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_we,
    input  logic [3*NREQ-1:0]    req_func3,
    input  logic [32*NREQ-1:0]   req_addr,
    input  logic [32*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]      resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [2:0]           mem_func3,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata
);

    import dmem_arbiter_pkg::*;

    localparam int PW = $clog2(NREQ);
    localparam int AW = $clog2(MEM_BYTES);

    arb_state_t  state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] gnt;
    logic [PW-1:0] sel;
    logic [PW-1:0] idx;
    logic [PW:0]   sum;
    logic          hit;

    logic        in_we;
    logic [2:0]  in_f3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;

    logic        lat_we;
    logic [2:0]  lat_f3;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        err;

    // First valid requester at or after rr_ptr, cyclically.
    always_comb begin
        sel = rr_ptr;
        hit = 1'b0;
        sum = '0;
        idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!hit && req_valid[idx]) begin
                sel = idx;
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        in_we    = 1'b0;
        in_f3    = '0;
        in_addr  = '0;
        in_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel == PW'(i)) begin
                in_we    = req_we[i];
                in_f3    = req_func3[3*i +: 3];
                in_addr  = req_addr[32*i +: 32];
                in_wdata = req_wdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = rst_n && (state == IDLE) && hit
                && (sel == PW'(i));
        end
    end

    dmem_access_check #(
        .MEM_BYTES (MEM_BYTES)
    ) u_check (
        .func3 (lat_f3),
        .we    (lat_we),
        .addr  (lat_addr),
        .err   (err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gnt        <= '0;
            lat_we     <= 1'b0;
            lat_f3     <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        gnt       <= sel;
                        lat_we    <= in_we;
                        lat_f3    <= in_f3;
                        lat_addr  <= in_addr;
                        lat_wdata <= in_wdata;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    resp_rdata <= (!lat_we && !err) ? mem_rdata : '0;
                    resp_err   <= err;
                    state      <= RESP;
                end
                RESP: begin
                    rr_ptr     <= (gnt == PW'(NREQ-1)) ? '0 : gnt + PW'(1);
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory sees nothing outside a legal ACCESS cycle.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_func3 = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if ((state == ACCESS) && !err) begin
            mem_read  = !lat_we;
            mem_write = lat_we;
            mem_func3 = lat_f3;
            mem_addr  = {{(32-AW){1'b0}}, lat_addr[AW-1:0]};
            mem_wdata = lat_wdata;
        end
    end

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            resp_valid[i] = (state == RESP) && (gnt == PW'(i));
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a byte-addressed memory model.
// Responses are queued at grant and checked by an independent monitor.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [5:0]  req_func3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_func3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    dmem_arbiter #(
        .NREQ      (2),
        .MEM_BYTES (512)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_func3  (req_func3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_func3  (mem_func3),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    req_t pend0[$];
    req_t pend1[$];
    exp_t sq0[$];
    exp_t sq1[$];

    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   bsy = 0;
    logic rr_m = 1'b0;

    logic [7:0]  mem [0:511];
    logic [8:0]  ra;
    logic [31:0] rw;
    logic [8:0]  wa;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational read with extension, write at clock edge.
    always_comb begin
        ra = mem_addr[8:0];
        rw = {mem[ra+9'd3], mem[ra+9'd2], mem[ra+9'd1], mem[ra]};
        mem_rdata = '0;
        if (mem_read) begin
            case (mem_func3)
                3'd0: mem_rdata = {{24{rw[7]}}, rw[7:0]};
                3'd4: mem_rdata = {24'd0, rw[7:0]};
                3'd1: mem_rdata = {{16{rw[15]}}, rw[15:0]};
                3'd5: mem_rdata = {16'd0, rw[15:0]};
                default: mem_rdata = rw;
            endcase
        end
    end

    always @(posedge clk) begin
        if (mem_write) begin
            wa = mem_addr[8:0];
            mem[wa] <= mem_wdata[7:0];
            if (mem_func3[1:0] != 2'd0) begin
                mem[wa+9'd1] <= mem_wdata[15:8];
            end
            if (mem_func3[1:0] == 2'd2) begin
                mem[wa+9'd2] <= mem_wdata[23:16];
                mem[wa+9'd3] <= mem_wdata[31:24];
            end
        end
    end

    function automatic logic [31:0] mword(input logic [8:0] a);
        return {mem[a+9'd3], mem[a+9'd2], mem[a+9'd1], mem[a]};
    endfunction

    function automatic req_t mk(input logic we, input logic [2:0] f3,
                                input logic [31:0] addr,
                                input logic [31:0] wdata,
                                input logic [31:0] rdata,
                                input logic err);
        req_t r;
        r.we = we;
        r.f3 = f3;
        r.addr = addr;
        r.wdata = wdata;
        r.rdata = rdata;
        r.err = err;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"}, {req_ready, resp_valid, resp_err,
                           mem_read, mem_write, mem_func3}, 64'd0);
        chk({nm, "_data"}, {resp_rdata, mem_addr}, 64'd0);
        chk({nm, "_wdata"}, {32'd0, mem_wdata}, 64'd0);
    endtask

    task automatic drive(input int i, input req_t r);
        req_we[i] = r.we;
        req_func3[3*i +: 3] = r.f3;
        req_addr[32*i +: 32] = r.addr;
        req_wdata[32*i +: 32] = r.wdata;
    endtask

    task automatic score(input int i);
        exp_t e;
        if ((i == 0 && sq0.size() == 0) || (i == 1 && sq1.size() == 0)) begin
            checks++;
            $display("FAIL resp_spurious: got resp_valid[%0d]=1 want 0", i);
        end else begin
            if (i == 0) e = sq0.pop_front();
            else e = sq1.pop_front();
            chk($sformatf("resp_rdata%0d", i), {32'd0, resp_rdata},
                {32'd0, e.rdata});
            chk($sformatf("resp_err%0d", i), {63'd0, resp_err},
                {63'd0, e.err});
            chk($sformatf("resp_latency%0d", i), 64'(cyc), 64'(e.due));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && resp_valid != 2'b00) begin
            chk("resp_onehot", {63'd0, $onehot(resp_valid)}, 64'd1);
            if (resp_valid[0]) score(0);
            if (resp_valid[1]) score(1);
        end
    end

    // Drives queued requests, holding each until granted.
    task automatic run_batch();
        int          guard;
        int          g;
        logic [1:0]  v;
        logic [1:0]  erdy;
        logic [1:0]  rdy;
        logic        cm;
        req_t        h;
        req_t        mreq;
        exp_t        e;
        guard = 0;
        cm = 1'b0;
        mreq = mk(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        while ((pend0.size() > 0 || pend1.size() > 0 || bsy > 0 || cm)
               && guard < 300) begin
            v = {pend1.size() > 0, pend0.size() > 0};
            if (v[0]) drive(0, pend0[0]);
            if (v[1]) drive(1, pend1[0]);
            req_valid = v;
            @(negedge clk);
            guard++;
            if (cm) begin
                if (mreq.err) begin
                    chk("mem_rw_on_err", {62'd0, mem_read, mem_write}, 64'd0);
                end else begin
                    chk("mem_ctl_addr",
                        {mem_read, mem_write, mem_func3, mem_addr},
                        {!mreq.we, mreq.we, mreq.f3,
                         mreq.addr & 32'h0000_01FF});
                    chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, mreq.wdata});
                end
                cm = 1'b0;
            end
            erdy = 2'b00;
            if (bsy == 0 && v != 2'b00) begin
                erdy = v[rr_m] ? (2'b01 << rr_m) : v;
            end
            rdy = req_ready;
            chk("req_ready", {62'd0, rdy}, {62'd0, erdy});
            if (bsy > 0) bsy--;
            if ((rdy == 2'b01 && v[0]) || (rdy == 2'b10 && v[1])) begin
                g = rdy[1] ? 1 : 0;
                if (g == 0) h = pend0.pop_front();
                else h = pend1.pop_front();
                e.rdata = h.rdata;
                e.err = h.err;
                e.due = cyc + 2;
                if (g == 0) sq0.push_back(e);
                else sq1.push_back(e);
                mreq = h;
                cm = 1'b1;
                bsy = 2;
                rr_m = !rdy[1];
            end
            @(posedge clk);
            #1;
        end
        req_valid = 2'b00;
        chk("batch_done", {63'd0, guard < 300}, 64'd1);
        chk("sb_drained", 64'(sq0.size() + sq1.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        rst_n = 1'b0;
        req_valid = 2'b11;
        req_we = 2'b00;
        req_func3 = '0;
        req_addr = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        req_valid = 2'b00;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Store then load back on requester 0.
        pend0.push_back(mk(1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0));
        pend0.push_back(mk(0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0));
        run_batch();

        // Sign and zero extension on requester 1.
        pend1.push_back(mk(1, 3'd2, 32'h20, 32'h0, 32'h0, 0));
        pend1.push_back(mk(1, 3'd0, 32'h21, 32'h80, 32'h0, 0));
        pend1.push_back(mk(0, 3'd0, 32'h21, 32'h0, 32'hFFFFFF80, 0));
        pend1.push_back(mk(0, 3'd4, 32'h21, 32'h0, 32'h00000080, 0));
        pend1.push_back(mk(0, 3'd5, 32'h20, 32'h0, 32'h00008000, 0));
        pend1.push_back(mk(0, 3'd1, 32'h20, 32'h0, 32'hFFFF8000, 0));
        run_batch();

        // Rejected accesses, then range boundary and unchanged memory.
        pend0.push_back(mk(1, 3'd2, 32'h13, 32'hFFFFFFFF, 32'h0, 1));
        pend0.push_back(mk(0, 3'd1, 32'h01, 32'h0, 32'h0, 1));
        pend0.push_back(mk(0, 3'd2, 32'h200, 32'h0, 32'h0, 1));
        pend0.push_back(mk(1, 3'd4, 32'h10, 32'hFF, 32'h0, 1));
        pend0.push_back(mk(0, 3'd7, 32'h10, 32'h0, 32'h0, 1));
        pend0.push_back(mk(0, 3'd2, 32'h80000010, 32'h0, 32'h0, 1));
        pend0.push_back(mk(1, 3'd2, 32'h1FC, 32'hCAFEF00D, 32'h0, 0));
        pend0.push_back(mk(0, 3'd2, 32'h1FC, 32'h0, 32'hCAFEF00D, 0));
        pend0.push_back(mk(0, 3'd4, 32'h1FF, 32'h0, 32'h000000CA, 0));
        pend0.push_back(mk(0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0));
        run_batch();

        // Contention: both requesters continuously valid.
        for (int k = 0; k < 6; k++) begin
            pend0.push_back(mk(1, 3'd2, 32'h40 + 32'(4*k),
                               32'hA0000000 + 32'(k), 32'h0, 0));
            pend1.push_back(mk(1, 3'd2, 32'h60 + 32'(4*k),
                               32'hB0000000 + 32'(k), 32'h0, 0));
        end
        run_batch();
        pend0.push_back(mk(0, 3'd2, 32'h54, 32'h0, 32'hA0000005, 0));
        pend0.push_back(mk(0, 3'd2, 32'h40, 32'h0, 32'hA0000000, 0));
        pend1.push_back(mk(0, 3'd2, 32'h60, 32'h0, 32'hB0000000, 0));
        pend1.push_back(mk(0, 3'd2, 32'h74, 32'h0, 32'hB0000005, 0));
        run_batch();

        // Backpressure: r1 waits while r0 owns the port.
        pend1.push_back(mk(0, 3'd4, 32'h1FF, 32'h0, 32'h000000CA, 0));
        run_batch();
        pend0.push_back(mk(0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0));
        pend1.push_back(mk(1, 3'd2, 32'h30, 32'h55AA55AA, 32'h0, 0));
        run_batch();
        pend0.push_back(mk(0, 3'd2, 32'h30, 32'h0, 32'h55AA55AA, 0));
        run_batch();

        // Reset during the ACCESS cycle of a store from r1.
        drive(1, mk(1, 3'd2, 32'h38, 32'h12345678, 32'h0, 0));
        req_valid = 2'b10;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!req_ready[1] && guard < 10);
        chk("abort_grant", {63'd0, req_ready[1]}, 64'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b01;
        chk("abort_pre", {mem_write, mem_addr}, {1'b1, 32'h38});
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        @(posedge clk);
        #1;
        chk("abort_mem", {32'd0, mword(9'h38)}, 64'd0);
        req_valid = 2'b00;
        bsy = 0;
        rr_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pend0.push_back(mk(0, 3'd2, 32'h38, 32'h0, 32'h0, 0));
        pend1.push_back(mk(0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0));
        run_batch();

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between NREQ requesters: core load/store unit on index 0, loader/debug/DMA masters on higher indices.
- Each requester uses a valid/ready request handshake and receives a one-cycle response pulse.
- Round-robin arbitration; at most one memory access in flight.
- Rejects misaligned, out-of-range and illegal-func3 accesses before they reach memory.

Parameters:
- NREQ, 2, number of requesters (legal 2..4).
- MEM_BYTES, 512, data-memory size in bytes; valid byte addresses are 0..MEM_BYTES-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  request valid, per requester
- req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
- req_we  in  NREQ  1=store, 0=load
- req_func3  in  NREQ x 3  access size/sign (F3_BYTE/HALF/WORD/UBYTE/UHALF)
- req_addr  in  NREQ x 32  byte address
- req_wdata  in  NREQ x 32  store data
- resp_valid  out  NREQ  response pulse to owning requester
- resp_rdata  out  32  load data, shared bus, valid with resp_valid
- resp_err  out  1  access rejected, valid with resp_valid
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_func3  out  3  to memory func3
- mem_addr  out  32  to memory addr
- mem_wdata  out  32  to memory w_data
- mem_rdata  in  32  from memory r_data (combinational read)

Behaviour:
- Reset (async, rst_n=0): state IDLE, rr_ptr=0, all outputs 0. The reset value of every output is 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req_valid, grant the first valid index at or after rr_ptr (cyclic) and assert req_ready[g] combinationally for that cycle.
  - On the same edge, latch we/func3/addr/wdata/g and the check result; go to ACCESS.
  - No other requester sees ready.
- Check (computed on the latched request):
  - err if func3 is in {3,6,7}.
  - err if store with func3 in {4,5}.
  - err if half/uhalf with addr[0]!=0.
  - err if word with addr[1:0]!=0.
  - err if addr+size-1 >= MEM_BYTES.
- ACCESS, one cycle:
  - If !err: drive mem_read=!we, mem_write=we, mem_func3/mem_addr/mem_wdata from the latch. The store commits at the end of this cycle.
  - If err: mem_read=mem_write=0.
  - On the edge, register resp_rdata = (load & !err) ? mem_rdata : 0, and register resp_err. Go to RESP.
- RESP, one cycle:
  - resp_valid[g]=1 only.
  - rr_ptr <= (g+1) mod NREQ; go to IDLE.
- Latency: handshake cycle T, memory cycle T+1, resp_valid at T+2. Next grant is possible at T+3.
- mem_* outputs are 0 in every state except ACCESS, so there are no spurious stores.
- Requesters must hold req_* stable while valid && !ready. The arbiter never drops a held request.
- Fairness: with all NREQ valid continuously, each requester is granted once every NREQ grants.
- Simultaneous valid and reset: reset wins. Reset asserted during ACCESS aborts the access; a partial store is not possible because the write commits at a clock edge.
- Address width: only addr bits needed for MEM_BYTES are forwarded. Upper bits participate only in the range check.

Decomposition:
- Shared package (extend the existing define header/pkg): F3_* codes, arb_state_t enum {IDLE, ACCESS, RESP}, access-size function func3 -> bytes.
- Sub-module dmem_access_check: combinational, takes func3/we/addr, outputs err. Reusable by the future dual-port RAM wrapper.

Test Plan:
- Single load: r0 loads word at 0x10 after a store of 0xDEADBEEF there -> resp_valid[0] at T+2, resp_rdata=0xDEADBEEF, resp_err=0.
- Sign/zero extension: store byte 0x80 at 0x21. LB -> 0xFFFFFF80; LBU -> 0x00000080; LHU at 0x20 -> 0x00008000.
- Contention: r0 and r1 both valid continuously, 6 requests each -> grants alternate 0,1,0,1..., no request lost, each response pulses only on the owner.
- Errors: SW at 0x13, LH at 0x01, LW at 0x200, SB with func3=4, func3=7 -> resp_err=1, resp_rdata=0, mem_write never asserted, memory contents unchanged.
- Reset mid-operation: drop rst_n during ACCESS of a store -> all outputs 0 immediately, FSM in IDLE, rr_ptr=0. After release, a fresh request completes normally.
- Backpressure stability: r1 held valid while r0 owns the port -> req_ready[1]=0 until r0's RESP completes, then r1 is granted with its original addr/wdata.
